// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage handshake between the pipeline front end and the
// hazard controller.
//   instr_d  - instruction held in D
//   valid_d  - instr_d is a real instruction (0 = bubble)
//   stall    - hold PC and F/D, inject a bubble into E
//   issue    - D instruction advances to E on this edge
//   md_busy  - multiply/divide unit busy
// The master modport is the pipeline side; the slave modport is the controller.
interface hazard_scoreboard_if;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        stall;
  logic        issue;
  logic        md_busy;

  modport master (
    output instr_d,
    output valid_d,
    input  stall,
    input  issue,
    input  md_busy
  );

  modport slave (
    input  instr_d,
    input  valid_d,
    output stall,
    output issue,
    output md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard controller for a MIPS pipeline.
// Classifies the D instruction, derives its sources (with Tuse) and destination (with Tnew),
// compares against a DEPTH-entry shift scoreboard of in-flight writers and a mult/div busy
// counter, and raises a combinational stall.
//   clk    - pipeline clock, rising edge
//   reset  - asynchronous, active-high
//   hz     - slave side of hazard_scoreboard_if (instr_d, valid_d in; stall, issue, md_busy out)
module hazard_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  hz
);

  localparam logic [CNT_W-1:0] MultLat = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DivLat  = CNT_W'(DIV_LAT);

  typedef enum logic [3:0] {
    ClsNone, ClsCalcR, ClsCalcI, ClsLui, ClsLoad, ClsStore, ClsBranch,
    ClsJ, ClsJal, ClsJr, ClsMt, ClsMf, ClsMcalc
  } cls_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } entry_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = hz.instr_d[31:26];
  assign rs = hz.instr_d[25:21];
  assign rt = hz.instr_d[20:16];
  assign rd = hz.instr_d[15:11];
  assign fn = hz.instr_d[5:0];

  cls_e cls;
  logic is_div;

  always_comb begin
    cls    = ClsNone;
    is_div = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2a, 6'h2b:               cls = ClsCalcR;
          6'h08:                                    cls = ClsJr;
          6'h10, 6'h12:                             cls = ClsMf;
          6'h11, 6'h13:                             cls = ClsMt;
          6'h18, 6'h19:                             cls = ClsMcalc;
          6'h1a, 6'h1b: begin
            cls    = ClsMcalc;
            is_div = 1'b1;
          end
          default:                                  cls = ClsNone;
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07:            cls = ClsBranch;
      6'h02:                                        cls = ClsJ;
      6'h03:                                        cls = ClsJal;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
      6'h0e:                                        cls = ClsCalcI;
      6'h0f:                                        cls = ClsLui;
      6'h1c:                                        cls = ClsMcalc;  // madd, mult latency
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:            cls = ClsLoad;
      6'h28, 6'h29, 6'h2b:                          cls = ClsStore;
      default:                                      cls = ClsNone;
    endcase
  end

  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic [4:0] dst;
  logic [1:0] tnew;

  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    dst     = 5'd0;
    tnew    = 2'd0;
    case (cls)
      ClsCalcR: begin
        dst     = rd;
        tnew    = 2'd1;
        // Immediate shifts (sll/srl/sra) read only rt.
        use_rs  = !(fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
        use_rt  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
      end
      ClsCalcI: begin
        dst     = rt;
        tnew    = 2'd1;
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
      end
      ClsLui: begin
        dst  = rt;
        tnew = 2'd1;
      end
      ClsLoad: begin
        dst     = rt;
        tnew    = 2'd2;
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
      end
      ClsStore: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      ClsBranch: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      ClsJr:    use_rs = 1'b1;
      ClsJal:   dst = 5'd31;
      ClsMt: begin
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
      end
      ClsMf: begin
        dst  = rd;
        tnew = 2'd1;
      end
      ClsMcalc: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
      end
      default: ;
    endcase
  end

  entry_t           sb_q [DEPTH];
  entry_t           sb_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reg_haz, md_haz;

  always_comb begin
    reg_haz = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sb_q[i].valid) begin
        if (use_rs && sb_q[i].dst == rs && sb_q[i].tnew > tuse_rs) reg_haz = 1'b1;
        if (use_rt && sb_q[i].dst == rt && sb_q[i].tnew > tuse_rt) reg_haz = 1'b1;
      end
    end
  end

  assign md_haz     = (cls == ClsMt || cls == ClsMf || cls == ClsMcalc) && (cnt_q != '0);
  assign hz.stall   = hz.valid_d & (reg_haz | md_haz);
  assign hz.issue   = hz.valid_d & ~hz.stall;
  assign hz.md_busy = (cnt_q != '0);

  always_comb begin
    // A $0 destination is recorded as an empty entry.
    sb_d[0] = '0;
    if (hz.issue && dst != 5'd0) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].dst   = dst;
      sb_d[0].tnew  = tnew;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sb_d[i]      = sb_q[i-1];
      sb_d[i].tnew = (sb_q[i-1].tnew != 2'd0) ? sb_q[i-1].tnew - 2'd1 : 2'd0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hz.issue && cls == ClsMcalc) begin
      cnt_d = is_div ? DivLat : MultLat;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  hazard_scoreboard_if hz ();

  hazard_scoreboard #(
    .DEPTH   (3),
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic v);
    hz.instr_d = instr;
    hz.valid_d = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(32'h0, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] lw8, lw2, addu9, sw8, beq8, beq3, addu3, beq9;
  logic [31:0] divi, multi, mflo4, addu0, beq0, jal, jr31;

  initial begin
    lw8   = itype(6'h23, 5'd1, 5'd8, 16'd0);
    lw2   = itype(6'h23, 5'd1, 5'd2, 16'd0);
    addu9 = rtype(5'd8, 5'd8, 5'd9, 6'h21);
    sw8   = itype(6'h2b, 5'd2, 5'd8, 16'd0);
    beq8  = itype(6'h04, 5'd8, 5'd0, 16'd4);
    beq3  = itype(6'h04, 5'd3, 5'd0, 16'd4);
    beq9  = itype(6'h04, 5'd9, 5'd0, 16'd4);
    addu3 = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    divi  = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    multi = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    mflo4 = rtype(5'd0, 5'd0, 5'd4, 6'h12);
    addu0 = rtype(5'd1, 5'd2, 5'd0, 6'h21);
    beq0  = itype(6'h04, 5'd0, 5'd0, 16'd4);
    jal   = {6'h03, 26'h40};
    jr31  = rtype(5'd31, 5'd0, 5'd0, 6'h08);

    // Reset state.
    drive(32'h0, 1'b0);
    chk("rst_md_busy", hz.md_busy, 1'b0);
    chk("rst_stall", hz.stall, 1'b0);
    chk("rst_issue_idle", hz.issue, 1'b0);
    drive(addu9, 1'b1);
    chk("rst_issue_valid", hz.issue, 1'b1);
    tick();
    reset = 1'b0;
    idle(2);

    // Load-use: one stall cycle.
    drive(lw8, 1'b1);
    chk("lu_lw_issue", hz.issue, 1'b1);
    tick();
    drive(addu9, 1'b1);
    chk("lu_stall_c1", hz.stall, 1'b1);
    chk("lu_issue_c1", hz.issue, 1'b0);
    tick();
    chk("lu_stall_c2", hz.stall, 1'b0);
    chk("lu_issue_c2", hz.issue, 1'b1);
    tick();
    idle(3);

    // Load-branch: two stall cycles.
    drive(lw8, 1'b1);
    tick();
    drive(beq8, 1'b1);
    chk("lb_stall_c1", hz.stall, 1'b1);
    tick();
    chk("lb_stall_c2", hz.stall, 1'b1);
    tick();
    chk("lb_issue_c3", hz.issue, 1'b1);
    tick();
    idle(3);

    // ALU-branch: one stall cycle.
    drive(addu3, 1'b1);
    tick();
    drive(beq3, 1'b1);
    chk("ab_stall_c1", hz.stall, 1'b1);
    tick();
    chk("ab_issue_c2", hz.issue, 1'b1);
    tick();
    idle(3);

    // Store data uses rt late; store base uses rs early.
    drive(lw8, 1'b1);
    tick();
    drive(sw8, 1'b1);
    chk("st_data_nostall", hz.stall, 1'b0);
    tick();
    idle(3);
    drive(lw2, 1'b1);
    tick();
    drive(sw8, 1'b1);
    chk("st_base_stall", hz.stall, 1'b1);
    tick();
    chk("st_base_issue", hz.issue, 1'b1);
    tick();
    idle(3);

    // div then mflo: busy t+1..t+10, mflo issues at t+11.
    drive(divi, 1'b1);
    chk("div_issue", hz.issue, 1'b1);
    chk("div_busy_t", hz.md_busy, 1'b0);
    tick();
    drive(mflo4, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("div_busy_t%0d", k), hz.md_busy, 1'b1);
      chk($sformatf("div_stall_t%0d", k), hz.stall, 1'b1);
      tick();
    end
    chk("div_busy_t11", hz.md_busy, 1'b0);
    chk("div_mflo_issue", hz.issue, 1'b1);
    tick();
    idle(3);

    // mult then mflo: mflo issues at t+6.
    drive(multi, 1'b1);
    chk("mul_issue", hz.issue, 1'b1);
    tick();
    drive(mflo4, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("mul_stall_t%0d", k), hz.stall, 1'b1);
      tick();
    end
    chk("mul_busy_t6", hz.md_busy, 1'b0);
    chk("mul_mflo_issue", hz.issue, 1'b1);
    tick();
    idle(3);

    // $0 destination and link register.
    drive(addu0, 1'b1);
    tick();
    drive(beq0, 1'b1);
    chk("zero_nostall", hz.stall, 1'b0);
    tick();
    drive(jal, 1'b1);
    tick();
    drive(jr31, 1'b1);
    chk("jal_jr_nostall", hz.stall, 1'b0);
    chk("jal_jr_issue", hz.issue, 1'b1);
    tick();
    idle(3);

    // Bubble in D never stalls.
    drive(lw8, 1'b1);
    tick();
    drive(addu9, 1'b0);
    chk("bubble_stall", hz.stall, 1'b0);
    chk("bubble_issue", hz.issue, 1'b0);
    tick();
    idle(3);

    // Reset mid-stall clears hazards and busy.
    drive(divi, 1'b1);
    tick();
    drive(lw8, 1'b1);
    chk("mr_lw_issue", hz.issue, 1'b1);
    tick();
    drive(addu9, 1'b1);
    chk("mr_pre_stall", hz.stall, 1'b1);
    chk("mr_pre_busy", hz.md_busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_stall", hz.stall, 1'b0);
    chk("mr_busy", hz.md_busy, 1'b0);
    chk("mr_issue", hz.issue, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_issue_rel", hz.issue, 1'b1);
    tick();
    // addu $9 entered E on that edge, so beq $9 must wait one cycle.
    drive(beq9, 1'b1);
    chk("mr_addu_seen", hz.stall, 1'b1);
    tick();
    chk("mr_beq_issue", hz.issue, 1'b1);
    tick();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised decode-stage hazard controller for the MIPS pipeline. It classifies the instruction in D and derives its register source/destination and Tuse/Tnew. It tracks in-flight writers in a DEPTH-entry shift scoreboard, plus a multiply/divide busy counter. It raises a single `stall` that freezes F/D and injects a bubble into E.

## Interface
- DEPTH, 3: scoreboard entries (E, M, W, …); legal range 2-8
- MULT_LAT, 5: busy cycles after mult/multu/madd enters E
- DIV_LAT, 10: busy cycles after div/divu enters E
- CNT_W, 4: busy-counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_d  in  32  instruction held in D
- valid_d  in  1  instr_d is a real instruction (0 = bubble)
- stall  out  1  combinational; hold PC and F/D, bubble into E
- issue  out  1  valid_d & ~stall; D instruction advances to E this edge
- md_busy  out  1  registered; busy counter non-zero

## Operation
- Decode classes: calc_r (R-type ALU incl. shifts; all-zero word is nop), calc_i (ori/andi/xori/addi/addiu/slti/sltiu), lui, load (lw/lh/lhu/lb/lbu), store (sw/sh/sb), branch (beq/bne/blez/bgtz/bltz/bgez), j, jal, jr, mt (mthi/mtlo), mf (mfhi/mflo), mcalc (mult/multu/div/divu, madd op 011100).
- Destination / Tnew at E: calc_r→rd/1; calc_i, lui→rt/1; load→rt/2; mf→rd/1; jal→31/0. Any other class has no destination. A destination of $0 is recorded as no destination.
- Tuse at D: branch rs,rt=0; jr rs=0; calc_r rs,rt=1 (sll/srl/sra rt only); calc_i, load, mt rs=1; store rs=1, rt=2; mcalc rs,rt=1. Other classes have no sources.
- Scoreboard entry fields: valid, dst[4:0], tnew[1:0]. Entry 0 is the E stage.
- Register hazard: for any valid entry i and used source s, if dst_i == s and tnew_i > tuse_s, stall.
- MDU hazard: if the D instruction is mt, mf, or mcalc and md_busy=1, stall.
- Shift on every clock edge:
  - entry[i] ← entry[i-1], with tnew decremented, saturating at 0.
  - Entry DEPTH-1 is discarded.
  - entry[0] ← decoded D instruction if issue=1, otherwise an invalid bubble.
- Busy counter:
  - On an edge with issue=1 and class mcalc, load MULT_LAT (mult/multu/madd) or DIV_LAT (div/divu).
  - Otherwise decrement if non-zero; saturate at 0.
  - md_busy = (counter != 0).
- A stalled D instruction is re-evaluated every cycle with no memory of prior stalls.
- With valid_d=0, stall=0 and issue=0.

## Timing
- Reset (async, immediate):
  - All entries invalid, tnew=0, dst=0; counter=0.
  - md_busy=0; stall=0 and issue=valid_d while reset is held.
- stall and issue are combinational from instr_d, valid_d, and registered state within the same cycle; no registered latency.
- Scoreboard and counter update only on the rising clk edge.
- A writer's hazard visibility begins the cycle after its issue edge.
- md_busy rises the cycle after the mcalc issue edge and stays high for exactly the loaded latency in cycles.
- Simultaneous events:
  - A stall cycle still shifts and decrements.
  - An mcalc can never load while busy, since it is itself stalled.
- Reset asserted mid-stall clears all hazards; the held D instruction issues on the first edge after release.
- DEPTH > 3 adds entries whose tnew is already 0; they never cause stalls.

## Test plan
- Reset: preload the scoreboard with lw $8, assert reset mid-cycle → md_busy=0 and stall=0 immediately; addu $9,$8,$8 then issues on the first edge after release.
- Load-use: lw $8,0($1) issued, then addu $9,$8,$8 in D → stall=1 for exactly 1 cycle, issue=1 on the 2nd cycle.
- Load-branch: lw $8, then beq $8,$0 → stall=1 for 2 cycles. For ALU-branch, addu $3,$1,$2 then beq $3,$0 → stall=1 for 1 cycle.
- Store data: lw $8, then sw $8,0($2) → no stall (rt Tuse=2). With lw $2 then sw $8,0($2) → 1-cycle stall.
- MDU: div $1,$2 issues at cycle t, mflo next in D → md_busy=1 for cycles t+1…t+10, mflo issues at t+11. Repeat with mult: issues at t+6.
- Zero/link cases:
  - addu $0,$1,$2 then beq $0,$0 → no stall.
  - jal then jr $31 → no stall.
  - valid_d=0 with any instr_d → stall=0.
